traffic_phase_scheduler: RTL and testbench
==========================================

// Module: traffic_phase_scheduler
// PURPOSE
//  Demand-actuated phase scheduler for the two-road intersection lamp bus {G1,Y1,R1,G2,Y2,R2}.
//  It replaces fixed-time cycling with three behaviours:
//   - the green is extended while vehicles are detected on that road;
//   - the green is yielded only when the other road, or a pedestrian, is waiting;
//   - an all-red walk phase is inserted when a pedestrian request is pending.
//  It sits between the sensor/button synchronisers and the lamp drivers on the board.
// PARAMETERS
//  TICK_DIV   100000000  clk cycles per timing tick (1 s at 100 MHz); bench overrides to 4
//  GREEN_MIN  5          minimum green, in ticks
//  GREEN_MAX  20         maximum green while the other road has demand, in ticks
//  YELLOW_T   3          yellow duration, in ticks
//  ALLRED_T   1          all-red clearance duration, in ticks
//  WALK_T     8          pedestrian walk duration, in ticks
//  Every *_T / GREEN_* value is 1..255 (8-bit phase timer).
// PORTS
//  clk       in   1  system clock
//  rst_n     in   1  reset; asynchronous, active-low
//  veh1_req  in   1  vehicle present on road 1 (synchronised level)
//  veh2_req  in   1  vehicle present on road 2 (synchronised level)
//  ped_req   in   1  pedestrian button (synchronised; a pulse of 1 cycle or longer)
//  ped_ack   out  1  1-cycle pulse on entry to WALK
//  walk      out  1  walk lamp; high only in WALK
//  lights    out  6  {G1,Y1,R1,G2,Y2,R2}
//  phase     out  3  current state code, for debug and LEDs
// BEHAVIOUR
//  Design: one clock; reset is asynchronous and active-low. All outputs are registered.
//  Reset values:
//   - state = AR2 (phase = 5), lights = 6'b001001, walk = 0, ped_ack = 0
//   - prescaler = 0, elapsed = 0, ped_pending = 0, walk_next = 0
//  Prescaler counts 0..TICK_DIV-1.
//   - tick = 1 when prescaler = TICK_DIV-1.
//   - The prescaler and elapsed both clear on every state change.
//   - A phase of N ticks therefore lasts exactly N*TICK_DIV cycles.
//  elapsed is an 8-bit count of completed ticks in the current state; it saturates at 255.
//   - All exit decisions are taken in the cycle where tick = 1, using en = elapsed + 1.
//  States (code, lights):
//   G1(0) 100001 | Y1(1) 010001 | AR1(2) 001001 | G2(3) 001100
//   Y2(4) 001010 | AR2(5) 001001 | WALK(6) 001001, walk = 1
//  Transitions:
//   - G1 -> Y1 when en >= GREEN_MIN and (veh2_req or ped_pending)
//     and (!veh1_req or en >= GREEN_MAX).
//   - If there is no such demand, G1 rests indefinitely.
//   - G2 mirrors G1, with veh1_req and veh2_req swapped.
//   - Y1 -> AR1 and Y2 -> AR2 when en = YELLOW_T.
//   - AR1 -> WALK if ped_pending (set walk_next = G2), else AR1 -> G2.
//   - AR2 -> WALK if ped_pending (set walk_next = G1), else AR2 -> G1.
//   - WALK -> walk_next when en = WALK_T.
//  Lights, walk and phase update on the same edge as the state register; there is no extra latency.
//  ped_pending:
//   - Set in any cycle with ped_req = 1, except in WALK, where ped_req is ignored.
//   - Cleared on the edge entering WALK; the clear wins over a simultaneous set.
//   - ped_ack = 1 for exactly the first cycle of WALK.
//  Simultaneous events:
//   - Both roads requesting at the tick where G1 reaches GREEN_MIN with veh1_req = 1:
//     hold G1 until GREEN_MAX, then yield.
//  Invariants (the bench asserts these):
//   - G1/Y1 are never lit together with G2/Y2.
//   - walk = 1 only when R1 = R2 = 1.
//  Reset mid-operation:
//   - On rst_n low, all outputs go to reset values immediately, without waiting for a clock edge.
//   - After release, the block clears through AR2 for ALLRED_T ticks, then enters G1,
//     or WALK if ped_req arrived after release.
//  Codes 7 is illegal; the block recovers to AR2 on the next edge.
// TESTING (TICK_DIV = 4, defaults otherwise)
//  1 Reset: rst_n = 0 -> lights = 001001, phase = 5, walk = 0.
//    Release with no requests -> lights = 100001 exactly 4 cycles later.
//  2 No demand: from G1 with all requests 0 -> G1 held for 400 cycles, with no output change.
//  3 Road-2 demand: veh2_req = 1, veh1_req = 0 in G1
//    -> G1 20 cycles, Y1 (010001) 12 cycles, AR1 4 cycles, then G2 (001100).
//  4 Extension: veh1_req = 1 and veh2_req = 1 held from G1 entry
//    -> G1 lasts 80 cycles (GREEN_MAX), then Y1.
//  5 Pedestrian: a 1-cycle ped_req pulse during G2 with veh1_req = 0
//    -> G2 exits at GREEN_MIN, Y2, AR2, then WALK.
//    -> In WALK: walk = 1 for 32 cycles, a single ped_ack pulse, then G1.
//    -> A ped_req pulse during WALK creates no second WALK.
//  6 Async reset in Y1: drop rst_n between clock edges
//    -> lights = 001001 and phase = 5 before the next edge, and walk = 0.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated two-road phase scheduler with pedestrian walk insertion.
// Drives the lamp bus {G1,Y1,R1,G2,Y2,R2}, the walk lamp and a debug phase code.
module traffic_phase_scheduler #(
    parameter int unsigned TICK_DIV  = 100000000,
    parameter int unsigned GREEN_MIN = 5,
    parameter int unsigned GREEN_MAX = 20,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned WALK_T    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       veh1_req,
    input  logic       veh2_req,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       walk,
    output logic [5:0] lights,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        G1   = 3'd0,
        Y1   = 3'd1,
        AR1  = 3'd2,
        G2   = 3'd3,
        Y2   = 3'd4,
        AR2  = 3'd5,
        WALK = 3'd6
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0] GMIN = 8'(GREEN_MIN);
    localparam logic [7:0] GMAX = 8'(GREEN_MAX);
    localparam logic [7:0] YEL  = 8'(YELLOW_T);
    localparam logic [7:0] ART  = 8'(ALLRED_T);
    localparam logic [7:0] WLK  = 8'(WALK_T);

    state_t        state_q, state_d;
    state_t        walk_next_q, walk_next_d;
    logic [PW-1:0] presc_q;
    logic [7:0]    elapsed_q;
    logic [7:0]    en;
    logic          ped_pending_q, ped_pending_d;
    logic          tick, change, enter_walk;
    logic [5:0]    lights_q;
    logic [2:0]    phase_q;
    logic          walk_q, ped_ack_q;

    function automatic logic [5:0] lamp(input state_t s);
        case (s)
            G1:      lamp = 6'b100001;
            Y1:      lamp = 6'b010001;
            G2:      lamp = 6'b001100;
            Y2:      lamp = 6'b001010;
            default: lamp = 6'b001001;
        endcase
    endfunction

    always_comb begin
        tick = (presc_q == PRESC_LAST);
        en = (elapsed_q == 8'hFF) ? 8'hFF : elapsed_q + 8'd1;
        state_d = state_q;
        walk_next_d = walk_next_q;
        case (state_q)
            G1: if (tick && en >= GMIN && (veh2_req || ped_pending_q)
                    && (!veh1_req || en >= GMAX)) state_d = Y1;
            G2: if (tick && en >= GMIN && (veh1_req || ped_pending_q)
                    && (!veh2_req || en >= GMAX)) state_d = Y2;
            Y1: if (tick && en == YEL) state_d = AR1;
            Y2: if (tick && en == YEL) state_d = AR2;
            AR1: if (tick && en == ART) begin
                if (ped_pending_q) begin
                    state_d = WALK;
                    walk_next_d = G2;
                end else begin
                    state_d = G2;
                end
            end
            AR2: if (tick && en == ART) begin
                if (ped_pending_q) begin
                    state_d = WALK;
                    walk_next_d = G1;
                end else begin
                    state_d = G1;
                end
            end
            WALK: if (tick && en == WLK) state_d = walk_next_q;
            default: state_d = AR2;
        endcase
        change = (state_d != state_q);
        enter_walk = (state_d == WALK) && (state_q != WALK);
        // Entering WALK serves the request, so the clear beats a same-cycle press.
        ped_pending_d = enter_walk ? 1'b0
                      : (ped_pending_q | (ped_req && state_q != WALK));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= AR2;
            walk_next_q   <= G1;
            presc_q       <= '0;
            elapsed_q     <= '0;
            ped_pending_q <= 1'b0;
            lights_q      <= 6'b001001;
            phase_q       <= 3'd5;
            walk_q        <= 1'b0;
            ped_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            walk_next_q   <= walk_next_d;
            ped_pending_q <= ped_pending_d;
            if (change) begin
                presc_q   <= '0;
                elapsed_q <= '0;
            end else begin
                presc_q <= tick ? '0 : presc_q + PW'(1);
                if (tick && elapsed_q != 8'hFF) elapsed_q <= elapsed_q + 8'd1;
            end
            lights_q  <= lamp(state_d);
            phase_q   <= state_d;
            walk_q    <= (state_d == WALK);
            ped_ack_q <= enter_walk;
        end
    end

    assign lights  = lights_q;
    assign phase   = phase_q;
    assign walk    = walk_q;
    assign ped_ack = ped_ack_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with TICK_DIV = 4.
// Each task drives one scenario and checks hand-computed phase lengths.
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       veh1_req = 1'b0;
    logic       veh2_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic       walk;
    logic [5:0] lights;
    logic [2:0] phase;

    int n_checks = 0;
    int n_fail = 0;

    traffic_phase_scheduler #(.TICK_DIV(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .veh1_req(veh1_req),
        .veh2_req(veh2_req),
        .ped_req(ped_req),
        .ped_ack(ped_ack),
        .walk(walk),
        .lights(lights),
        .phase(phase)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_checks++;
        if ((lights[5] | lights[4]) && (lights[2] | lights[1])) begin
            n_fail++;
            $display("FAIL inv_conflict lights=%b", lights);
        end
        n_checks++;
        if (walk && !(lights[3] && lights[0])) begin
            n_fail++;
            $display("FAIL inv_walk_red walk=%b lights=%b", walk, lights);
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic measure(input logic [2:0] ph, input int maxc, output int n);
        n = 0;
        while (phase === ph && n < maxc) begin
            n++;
            cyc();
        end
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if (lights !== 6'b001001) begin
            n_fail++;
            $display("FAIL rst_lights got=%b exp=001001", lights);
        end
        n_checks++;
        if (phase !== 3'd5) begin
            n_fail++;
            $display("FAIL rst_phase got=%0d exp=5", phase);
        end
        n_checks++;
        if (walk !== 1'b0 || ped_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_walk got=%b/%b exp=0/0", walk, ped_ack);
        end
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        n_checks++;
        if (lights !== 6'b001001) begin
            n_fail++;
            $display("FAIL rst_ar2_hold got=%b exp=001001", lights);
        end
        cyc();
        n_checks++;
        if (lights !== 6'b100001 || phase !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_to_g1 got=%b/%0d exp=100001/0", lights, phase);
        end
    endtask

    task automatic test_road2;
        int n;
        veh1_req = 1'b0;
        veh2_req = 1'b1;
        measure(3'd0, 200, n);
        n_checks++;
        if (n != 20) begin
            n_fail++;
            $display("FAIL road2_g1_len got=%0d exp=20", n);
        end
        n_checks++;
        if (lights !== 6'b010001) begin
            n_fail++;
            $display("FAIL road2_y1_lights got=%b exp=010001", lights);
        end
        measure(3'd1, 200, n);
        n_checks++;
        if (n != 12) begin
            n_fail++;
            $display("FAIL road2_y1_len got=%0d exp=12", n);
        end
        measure(3'd2, 200, n);
        n_checks++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL road2_ar1_len got=%0d exp=4", n);
        end
        n_checks++;
        if (lights !== 6'b001100 || phase !== 3'd3) begin
            n_fail++;
            $display("FAIL road2_g2 got=%b/%0d exp=001100/3", lights, phase);
        end
    endtask

    task automatic test_pedestrian;
        int n, nw, nwalk, nack;
        veh1_req = 1'b0;
        veh2_req = 1'b0;
        ped_req = 1'b1;
        cyc();
        ped_req = 1'b0;
        measure(3'd3, 200, n);
        n_checks++;
        if (n + 1 != 20) begin
            n_fail++;
            $display("FAIL ped_g2_len got=%0d exp=20", n + 1);
        end
        n_checks++;
        if (lights !== 6'b001010) begin
            n_fail++;
            $display("FAIL ped_y2_lights got=%b exp=001010", lights);
        end
        measure(3'd4, 200, n);
        n_checks++;
        if (n != 12) begin
            n_fail++;
            $display("FAIL ped_y2_len got=%0d exp=12", n);
        end
        measure(3'd5, 200, n);
        n_checks++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL ped_ar2_len got=%0d exp=4", n);
        end
        nw = 0;
        nwalk = 0;
        nack = 0;
        while (phase === 3'd6 && nw < 100) begin
            nw++;
            if (walk === 1'b1) nwalk++;
            if (ped_ack === 1'b1) nack++;
            ped_req = (nw == 5);
            cyc();
        end
        ped_req = 1'b0;
        n_checks++;
        if (nw != 32 || nwalk != 32) begin
            n_fail++;
            $display("FAIL ped_walk_len got=%0d/%0d exp=32/32", nw, nwalk);
        end
        n_checks++;
        if (nack != 1) begin
            n_fail++;
            $display("FAIL ped_ack_count got=%0d exp=1", nack);
        end
        n_checks++;
        if (phase !== 3'd0 || walk !== 1'b0 || ped_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL ped_to_g1 got=%0d/%b/%b exp=0/0/0",
                     phase, walk, ped_ack);
        end
    endtask

    task automatic test_extension;
        int n;
        veh1_req = 1'b1;
        veh2_req = 1'b1;
        measure(3'd0, 400, n);
        n_checks++;
        if (n != 80) begin
            n_fail++;
            $display("FAIL ext_g1_len got=%0d exp=80", n);
        end
        measure(3'd1, 200, n);
        n_checks++;
        if (n != 12) begin
            n_fail++;
            $display("FAIL ext_y1_len got=%0d exp=12", n);
        end
        measure(3'd2, 200, n);
        n_checks++;
        if (n != 4 || phase !== 3'd3) begin
            n_fail++;
            $display("FAIL ext_no_second_walk got=%0d/%0d exp=4/3", n, phase);
        end
        veh1_req = 1'b1;
        veh2_req = 1'b0;
        measure(3'd3, 200, n);
        n_checks++;
        if (n != 20) begin
            n_fail++;
            $display("FAIL ext_g2_len got=%0d exp=20", n);
        end
        measure(3'd4, 200, n);
        measure(3'd5, 200, n);
        n_checks++;
        if (phase !== 3'd0) begin
            n_fail++;
            $display("FAIL ext_back_g1 got=%0d exp=0", phase);
        end
        veh1_req = 1'b0;
    endtask

    task automatic test_no_demand;
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (phase !== 3'd0 || lights !== 6'b100001 || walk !== 1'b0) bad++;
            cyc();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL no_demand_hold got=%0d bad cycles exp=0", bad);
        end
    endtask

    task automatic test_async_reset;
        int n;
        veh2_req = 1'b1;
        n = 0;
        while (phase !== 3'd1 && n < 50) begin
            n++;
            cyc();
        end
        n_checks++;
        if (phase !== 3'd1) begin
            n_fail++;
            $display("FAIL areset_reach_y1 got=%0d exp=1", phase);
        end
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (lights !== 6'b001001 || phase !== 3'd5 || walk !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_async got=%b/%0d/%b exp=001001/5/0",
                     lights, phase, walk);
        end
        veh2_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        ped_req = 1'b1;
        cyc();
        ped_req = 1'b0;
        cyc();
        cyc();
        n_checks++;
        if (phase !== 3'd5) begin
            n_fail++;
            $display("FAIL areset_ar2_hold got=%0d exp=5", phase);
        end
        cyc();
        n_checks++;
        if (phase !== 3'd6 || walk !== 1'b1 || ped_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_walk got=%0d/%b/%b exp=6/1/1",
                     phase, walk, ped_ack);
        end
    endtask

    initial begin
        test_reset();
        test_road2();
        test_pedestrian();
        test_extension();
        test_no_demand();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
